// File: rtl/pmem_pkg.sv
// Shared types and geometry for the cache-line to 64-bit burst adaptor.
package pmem_pkg;

  localparam int PMEM_BEATS  = 4;
  localparam int PMEM_BEAT_W = 64;
  localparam int PMEM_LINE_W = 256;
  localparam int PMEM_OFFSET = 5;
  localparam int PMEM_IDX_W  = $clog2(PMEM_BEATS);

  localparam logic [31:0] PMEM_ADDR_MASK = ~((32'd1 << PMEM_OFFSET) - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_BEAT,
    ST_WR_BEAT,
    ST_DONE
  } pmem_state_e;

endpackage

// File: rtl/pmem_line_adaptor_beat_buffer.sv
// 4x64 beat register file holding the in-flight line: beat write/read by
// index, full-line load and full-line view.
module pmem_beat_buffer
  import pmem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [PMEM_LINE_W-1:0] load_line,
  input  logic                   we,
  input  logic [PMEM_IDX_W-1:0]  wr_idx,
  input  logic [PMEM_BEAT_W-1:0] wr_data,
  input  logic [PMEM_IDX_W-1:0]  rd_idx,
  output logic [PMEM_BEAT_W-1:0] rd_data,
  output logic [PMEM_LINE_W-1:0] line
);

  logic [PMEM_BEAT_W-1:0] beats [PMEM_BEATS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PMEM_BEATS; i++) beats[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < PMEM_BEATS; i++) beats[i] <= load_line[i*PMEM_BEAT_W +: PMEM_BEAT_W];
    end else if (we) begin
      beats[wr_idx] <= wr_data;
    end
  end

  assign rd_data = beats[rd_idx];

  always_comb begin
    line = '0;
    for (int i = 0; i < PMEM_BEATS; i++) line[i*PMEM_BEAT_W +: PMEM_BEAT_W] = beats[i];
  end

endmodule

// File: rtl/pmem_line_adaptor.sv
// Cache line port to 4-beat 64-bit burst bus adaptor.
// Optional watchdog enabled by defining PMEM_ADAPTOR_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for a line read/write request
// RD_REQ     | read_o asserted, waiting for first beat
// RD_BEAT    | collecting remaining read beats
// WR_BEAT    | write_o asserted, presenting beat[count]
// DONE       | one-cycle resp_o with assembled line
module pmem_line_adaptor
  import pmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  output logic         error_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  output logic [63:0]  burst_o,
  input  logic [63:0]  burst_i,
  input  logic         resp_i
);

`ifdef PMEM_ADAPTOR_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  pmem_state_e state, state_nxt;
  logic [PMEM_IDX_W-1:0]  count, count_nxt;
  logic [31:0]            addr_q;
  logic                   latch_addr;
  logic                   buf_load, buf_we;
  logic [PMEM_LINE_W-1:0] load_line, buf_line;
  logic [PMEM_BEAT_W-1:0] beat_rd;
  logic [WD_W-1:0]        wd;
  logic                   err;
  logic                   active, timeout;

  pmem_beat_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_line (load_line),
    .we        (buf_we),
    .wr_idx    (count),
    .wr_data   (burst_i),
    .rd_idx    (count),
    .rd_data   (beat_rd),
    .line      (buf_line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (latch_addr) addr_q <= address_i & PMEM_ADDR_MASK;
    end
  end

  assign active = (state == ST_RD_REQ) || (state == ST_RD_BEAT) || (state == ST_WR_BEAT);

  // Down-counting watchdog; reloaded in IDLE and on every memory strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd  <= WD_W'(TIMEOUT);
      err <= 1'b0;
    end else begin
      if ((state == ST_IDLE) || resp_i) wd <= WD_W'(TIMEOUT);
      else if (active && (wd != '0)) wd <= wd - 1'b1;
      if (timeout) err <= 1'b1;
    end
  end

  assign timeout = WD_EN && active && (wd == '0);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    latch_addr = 1'b0;
    buf_load   = 1'b0;
    buf_we     = 1'b0;
    load_line  = '0;
    case (state)
      ST_IDLE: begin
        count_nxt = '0;
        if (write_i) begin
          latch_addr = 1'b1;
          buf_load   = 1'b1;
          load_line  = line_i;
          state_nxt  = ST_WR_BEAT;
        end else if (read_i) begin
          // Zero the buffer so a watchdog abort returns 0 for missing beats.
          latch_addr = 1'b1;
          buf_load   = 1'b1;
          state_nxt  = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (resp_i) begin
          buf_we    = 1'b1;
          count_nxt = count + 1'b1;
          state_nxt = ST_RD_BEAT;
        end
      end
      ST_RD_BEAT: begin
        if (resp_i) begin
          buf_we    = 1'b1;
          count_nxt = count + 1'b1;
          if (count == PMEM_IDX_W'(PMEM_BEATS - 1)) state_nxt = ST_DONE;
        end
      end
      ST_WR_BEAT: begin
        if (resp_i) begin
          count_nxt = count + 1'b1;
          if (count == PMEM_IDX_W'(PMEM_BEATS - 1)) state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (timeout) begin
      buf_we    = 1'b0;
      count_nxt = '0;
      state_nxt = ST_DONE;
    end
  end

  assign read_o    = (state == ST_RD_REQ);
  assign write_o   = (state == ST_WR_BEAT);
  assign resp_o    = (state == ST_DONE);
  assign line_o    = (state == ST_DONE) ? buf_line : '0;
  assign burst_o   = (state == ST_WR_BEAT) ? beat_rd : '0;
  assign address_o = addr_q;
  assign error_o   = err;

endmodule

// File: tb/tb_pmem_line_adaptor.sv
// Scoreboard bench for pmem_line_adaptor: stimulus pushes expected line
// responses and write beats; a negedge monitor pops and compares.
module tb_pmem_line_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i, write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o, error_o;
  logic [31:0]  address_o;
  logic         read_o, write_o;
  logic [63:0]  burst_o, burst_i;
  logic         resp_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [255:0] line;
    logic         err;
    logic [31:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] wbeat_q[$];

  pmem_line_adaptor #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .error_o   (error_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every resp_o pulse and every accepted write beat.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (resp_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_o=1 want no response at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_line", line_o, e.line);
          chk("resp_error", {255'd0, error_o}, {255'd0, e.err});
          chk("resp_addr", {224'd0, address_o}, {224'd0, e.addr});
        end
      end
      if (write_o && resp_i) begin
        if (wbeat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_wbeat: got beat %h want none at %0t", burst_o, $time);
        end else begin
          chk("write_beat", {192'd0, burst_o}, {192'd0, wbeat_q.pop_front()});
        end
      end
    end
  end

  // One line transaction; stall cycles inserted before beat 2. Inputs are
  // scrambled after the request edge to confirm the DUT latched them.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline, input int stall);
    exp_t e;
    logic is_wr;
    is_wr  = wr;
    e.line = is_wr ? wline : rline;
    e.err  = 1'b0;
    e.addr = {addr[31:5], 5'b0};
    exp_q.push_back(e);
    if (is_wr) for (int k = 0; k < 4; k++) wbeat_q.push_back(wline[64*k +: 64]);
    address_i = addr; read_i = rd; write_i = wr; line_i = wline;
    @(posedge clk); #1;
    address_i = 32'hFFFF_FFFF; line_i = '1;
    chk("address_o", {224'd0, address_o}, {224'd0, e.addr});
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        for (int s = 0; s < stall; s++) begin
          resp_i = 1'b0; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
          chk("stall_read_o", {255'd0, read_o}, 256'd0);
          chk("stall_resp_o", {255'd0, resp_o}, 256'd0);
          if (is_wr) chk("burst_hold", {192'd0, burst_o}, {192'd0, wline[128 +: 64]});
          @(posedge clk); #1;
        end
      end
      chk("read_o", {255'd0, read_o}, {255'd0, (!is_wr && k == 0)});
      chk("write_o", {255'd0, write_o}, {255'd0, is_wr});
      chk("early_resp", {255'd0, resp_o}, 256'd0);
      resp_i  = 1'b1;
      burst_i = is_wr ? 64'h0BAD_0BAD_0BAD_0BAD : rline[64*k +: 64];
      @(posedge clk); #1;
    end
    resp_i = 1'b0; burst_i = '0;
    chk("resp_latency", {255'd0, resp_o}, 256'd1);
    chk("write_dropped", {255'd0, write_o}, 256'd0);
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
    chk("resp_one_cycle", {255'd0, resp_o}, 256'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_line_o"}, line_o, '0);
    chk({tag, "_ctl"}, {251'd0, resp_o, error_o, read_o, write_o, 1'b0}, '0);
    chk({tag, "_burst_o"}, {192'd0, burst_o}, '0);
    chk({tag, "_address_o"}, {224'd0, address_o}, '0);
  endtask

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;

  initial begin
    exp_t e;
    rst = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0; line_i = '0;
    burst_i = '0; resp_i = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // zero-wait read
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, {B4, B3, B2, B1}, 0);
    @(posedge clk); #1;

    // write with a 2-cycle stall between beats 1 and 2
    run_txn(1'b0, 1'b1, 32'h0000_0800, {8{32'hDEAD_BEEF}}, '0, 2);
    @(posedge clk); #1;

    // simultaneous read and write: write must win
    run_txn(1'b1, 1'b1, 32'h0000_0C3F,
            {64'hA4A4_A4A4_0000_0004, 64'hA3A3_A3A3_0000_0003,
             64'hA2A2_A2A2_0000_0002, 64'hA1A1_A1A1_0000_0001}, '0, 0);
    @(posedge clk); #1;

    // reset during a read after beat 1
    address_i = 32'h0000_0100; read_i = 1'b1;
    @(posedge clk); #1;
    resp_i = 1'b1; burst_i = 64'hDEAD_0000_0000_0000;
    @(posedge clk); #1;
    burst_i = 64'hDEAD_0000_0000_0001;
    @(posedge clk); #1;
    resp_i = 1'b0; burst_i = '0;
    chk("pre_reset_addr", {224'd0, address_o}, {224'd0, 32'h0000_0100});
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    read_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 32'h0000_0200,
            '0, {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                 64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000}, 1);

    // back-to-back: read then write to 0x40 with a one-cycle gap
    run_txn(1'b1, 1'b0, 32'h0000_005F, '0,
            {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
             64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101}, 0);
    @(posedge clk); #1;
    run_txn(1'b0, 1'b1, 32'h0000_0040,
            {64'hF4F4_F4F4_F4F4_F4F4, 64'hF3F3_F3F3_F3F3_F3F3,
             64'hF2F2_F2F2_F2F2_F2F2, 64'hF1F1_F1F1_F1F1_F1F1}, '0, 0);
    @(posedge clk); #1;

    // memory never responds
    address_i = 32'h0000_2000; read_i = 1'b1;
`ifdef PMEM_ADAPTOR_TIMEOUT_EN
    e.line = '0; e.err = 1'b1; e.addr = 32'h0000_2000;
    exp_q.push_back(e);
    @(posedge clk); #1;
    for (int c = 1; c < 18; c++) begin
      chk("timeout_early_resp", {255'd0, resp_o}, 256'd0);
      @(posedge clk); #1;
    end
    chk("timeout_resp", {255'd0, resp_o}, 256'd1);
    @(posedge clk); #1;
    read_i = 1'b0;
    chk("timeout_error_sticky", {255'd0, error_o}, 256'd1);
    chk("timeout_line_after", line_o, '0);
    chk("timeout_one_pulse", {255'd0, resp_o}, 256'd0);
`else
    @(posedge clk); #1;
    for (int c = 1; c < 40; c++) begin
      chk("hang_resp", {255'd0, resp_o}, 256'd0);
      chk("hang_error", {255'd0, error_o}, 256'd0);
      chk("hang_read_o", {255'd0, read_o}, 256'd1);
      @(posedge clk); #1;
    end
    read_i = 1'b0;
    rst = 1'b1;
    #1;
    check_outputs_zero("hang_reset");
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", {224'd0, 32'(exp_q.size())}, 256'd0);
    chk("wbeats_drained", {224'd0, 32'(wbeat_q.size())}, 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
